sevenseg_scan_ctrl: RTL and testbench

Display controller for the binary-counting game. It accepts an 8-bit binary score or answer over a valid/ready handshake and converts it to three BCD digits with a sequential double-dabble (one shift per clock). It time-multiplexes those digits through the single shared `sevenseg_decoder` instance, which is driven by `digit_code`, and produces one-hot digit enables. Dead-time blanking between digits prevents ghosting, and leading-zero suppression is optional.

---
 rtl/sevenseg_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Three-digit seven-segment scan controller: sequential double-dabble conversion of an
// 8-bit value into BCD, then time-multiplexed digit codes with dead-time blanking.
module sevenseg_scan_ctrl #(
   parameter int DIV_WIDTH    = 10,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] value_in,
   input  logic       value_valid,
   output logic       value_ready,
   input  logic       blank_lz,
   input  logic       display_en,
   output logic [3:0] digit_code,
   output logic [2:0] digit_sel,
   output logic       busy
);

   // Handshake: a value transfers on a rising edge where value_valid and value_ready are
   // both high; value_valid seen while value_ready is low is ignored, never queued.

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   localparam logic [DIV_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [DIV_WIDTH-1:0] LIMIT   = DIV_WIDTH'((1 << DIV_WIDTH) - BLANK_CYCLES);

   state_t                 state;
   state_t                 state_n;
   logic                   accept;
   logic                   last_step;
   logic [7:0]             shreg;
   logic [11:0]            bcd;
   logic [2:0]             step;
   logic [11:0]            adj;
   logic [19:0]            shifted;
   logic [3:0]             d0;
   logic [3:0]             d1;
   logic [3:0]             d2;
   logic [DIV_WIDTH-1:0]   cnt;
   logic [1:0]             idx;
   logic [3:0]             cur_code;
   logic [2:0]             cur_onehot;
   logic                   cur_supp;
   logic [2:0]             sel_n;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? 4'(n + 4'd3) : n;
   endfunction

   always_comb begin
      state_n   = state;
      accept    = 1'b0;
      last_step = 1'b0;
      case (state)
         IDLE: begin
            if (value_valid) begin
               accept  = 1'b1;
               state_n = CONV;
            end
         end
         CONV: begin
            if (step == 3'd7) begin
               last_step = 1'b1;
               state_n   = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   assign value_ready = (state == IDLE);
   assign busy        = ~value_ready;

   // One double-dabble step: correct every nibble >= 5, then shift {bcd, shreg} left.
   assign adj     = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
   assign shifted = {adj, shreg[7:0]} << 1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg <= '0;
         bcd   <= '0;
         step  <= '0;
         d0    <= '0;
         d1    <= '0;
         d2    <= '0;
      end else if (accept) begin
         shreg <= value_in;
         bcd   <= '0;
         step  <= '0;
      end else if (state == CONV) begin
         shreg <= shifted[7:0];
         bcd   <= shifted[19:8];
         step  <= step + 3'd1;
         if (last_step) begin
            d0 <= shifted[11:8];
            d1 <= shifted[15:12];
            d2 <= shifted[19:16];
         end
      end
   end

   always_comb begin
      cur_code   = 4'd0;
      cur_onehot = 3'b000;
      cur_supp   = 1'b0;
      case (idx)
         2'd0: begin
            cur_code   = d0;
            cur_onehot = 3'b001;
         end
         2'd1: begin
            cur_code   = d1;
            cur_onehot = 3'b010;
            cur_supp   = blank_lz && (d2 == 4'd0) && (d1 == 4'd0);
         end
         2'd2: begin
            cur_code   = d2;
            cur_onehot = 3'b100;
            cur_supp   = blank_lz && (d2 == 4'd0);
         end
         default: begin
            cur_code   = 4'd0;
            cur_onehot = 3'b000;
         end
      endcase
      // The tail of every digit period stays dark so the next digit never ghosts.
      sel_n = (cnt < LIMIT && display_en && !cur_supp) ? cur_onehot : 3'b000;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         idx        <= '0;
         digit_code <= '0;
         digit_sel  <= '0;
      end else begin
         cnt <= cnt + DIV_WIDTH'(1);
         if (cnt == CNT_MAX) idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
         digit_code <= cur_code;
         digit_sel  <= sel_n;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl with a 16-cycle digit period and 2 blank cycles; expected
// scan outputs come from an arithmetic BCD model and a bench-side cycle count.
module tb_sevenseg_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] value_in = 8'd0;
   logic       value_valid = 1'b0;
   logic       value_ready;
   logic       blank_lz = 1'b0;
   logic       display_en = 1'b1;
   logic [3:0] digit_code;
   logic [2:0] digit_sel;
   logic       busy;

   int         errors = 0;
   int         checks = 0;
   int         tcyc = 0;
   logic [3:0] exp_d2 = 4'd0;
   logic [3:0] exp_d1 = 4'd0;
   logic [3:0] exp_d0 = 4'd0;
   logic [6:0] exp_q[$];
   logic [6:0] got;
   logic [6:0] want;

   sevenseg_scan_ctrl #(.DIV_WIDTH(4), .BLANK_CYCLES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value_in    (value_in),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .blank_lz    (blank_lz),
      .display_en  (display_en),
      .digit_code  (digit_code),
      .digit_sel   (digit_sel),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Number of rising edges seen with reset released.
   always @(posedge clk) begin
      if (!rst_n) tcyc <= 0;
      else        tcyc <= tcyc + 1;
   end

   function automatic logic [6:0] exp_out(input int k, input logic [3:0] e2, input logic [3:0] e1,
                                          input logic [3:0] e0, input logic blz, input logic den);
      int         c;
      int         i;
      logic [3:0] code;
      logic       supp;
      logic [2:0] sel;
      if (k <= 0) return 7'd0;
      c    = (k - 1) % 16;
      i    = ((k - 1) / 16) % 3;
      code = (i == 0) ? e0 : (i == 1) ? e1 : e2;
      supp = blz && ((i == 2 && e2 == 4'd0) || (i == 1 && e2 == 4'd0 && e1 == 4'd0));
      sel  = (c < 14 && den && !supp) ? 3'(1 << i) : 3'b000;
      return {code, sel};
   endfunction

   task automatic set_expected(input int v);
      exp_d2 = 4'(v / 100);
      exp_d1 = 4'((v / 10) % 10);
      exp_d0 = 4'(v % 10);
   endtask

   // Drive one cycle of display inputs and queue the output expected after the next edge.
   task automatic scan_step(input logic den);
      display_en = den;
      exp_q.push_back(exp_out(tcyc + 1, exp_d2, exp_d1, exp_d0, blank_lz, den));
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!value_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!value_ready) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: value_ready=%b after %0d cycles, want 1", value_ready, n);
      end
   endtask

   task automatic send_value(input logic [7:0] v);
      wait_idle();
      value_in    = v;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      wait_idle();
      set_expected(int'(v));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks += 4;
      if (value_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", value_ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (digit_sel !== 3'b000) begin errors++; $display("FAIL reset_sel: got %b want 000", digit_sel); end
      if (digit_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", digit_code); end
      rst_n = 1'b1;
      set_expected(0);
      for (int j = 0; j < 48; j++) begin
         scan_step(1'b1);
         got  = {digit_code, digit_sel};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL idle_scan cyc %0d: got code=%0d sel=%b want code=%0d sel=%b",
                     j, got[6:3], got[2:0], want[6:3], want[2:0]);
         end
      end
      checks++;
      if (value_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", value_ready); end
   endtask

   task automatic test_convert();
      value_in    = 8'd237;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         checks++;
         if (value_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL conv_busy step %0d: got ready=%b busy=%b want ready=0 busy=1", j, value_ready, busy);
         end
         @(negedge clk);
      end
      checks++;
      if (value_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL conv_done: got ready=%b busy=%b want ready=1 busy=0", value_ready, busy);
      end
      set_expected(237);
      for (int j = 0; j < 48; j++) begin
         scan_step(1'b1);
         got  = {digit_code, digit_sel};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL scan_237 cyc %0d: got code=%0d sel=%b want code=%0d sel=%b",
                     j, got[6:3], got[2:0], want[6:3], want[2:0]);
         end
      end
   endtask

   task automatic test_leading_zero();
      int vals[4] = '{5, 40, 100, 0};
      blank_lz = 1'b1;
      foreach (vals[v]) begin
         send_value(8'(vals[v]));
         for (int j = 0; j < 48; j++) begin
            scan_step(1'b1);
            got  = {digit_code, digit_sel};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL lz_%0d cyc %0d: got code=%0d sel=%b want code=%0d sel=%b",
                        vals[v], j, got[6:3], got[2:0], want[6:3], want[2:0]);
            end
         end
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_busy_ignore();
      value_in    = 8'd12;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      repeat (2) @(negedge clk);
      value_in    = 8'd99;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      checks++;
      if (value_ready !== 1'b0) begin errors++; $display("FAIL ignore_ready: got %b want 0", value_ready); end
      wait_idle();
      set_expected(12);
      for (int j = 0; j < 48; j++) begin
         scan_step(1'b1);
         got  = {digit_code, digit_sel};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL ignore_012 cyc %0d: got code=%0d sel=%b want code=%0d sel=%b",
                     j, got[6:3], got[2:0], want[6:3], want[2:0]);
         end
      end
      checks++;
      if (value_ready !== 1'b1) begin errors++; $display("FAIL ignore_idle: got %b want 1", value_ready); end
      send_value(8'd99);
      for (int j = 0; j < 48; j++) begin
         scan_step(1'b1);
         got  = {digit_code, digit_sel};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL after_99 cyc %0d: got code=%0d sel=%b want code=%0d sel=%b",
                     j, got[6:3], got[2:0], want[6:3], want[2:0]);
         end
      end
   endtask

   task automatic test_reset_mid_conv();
      value_in    = 8'd255;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks += 4;
      if (value_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", value_ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      if (digit_sel !== 3'b000) begin errors++; $display("FAIL midrst_sel: got %b want 000", digit_sel); end
      if (digit_code !== 4'd0) begin errors++; $display("FAIL midrst_code: got %0d want 0", digit_code); end
      rst_n = 1'b1;
      set_expected(0);
      for (int j = 0; j < 48; j++) begin
         scan_step(1'b1);
         got  = {digit_code, digit_sel};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL midrst_scan cyc %0d: got code=%0d sel=%b want code=%0d sel=%b",
                     j, got[6:3], got[2:0], want[6:3], want[2:0]);
         end
      end
   endtask

   task automatic test_display_en();
      send_value(8'(8'd100 + 8'($urandom_range(0, 155))));
      for (int j = 0; j < 64; j++) begin
         scan_step(!(j >= 20 && j < 40));
         got  = {digit_code, digit_sel};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL den_scan cyc %0d: got code=%0d sel=%b want code=%0d sel=%b",
                     j, got[6:3], got[2:0], want[6:3], want[2:0]);
         end
      end
      display_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_convert();
      test_leading_zero();
      test_busy_ignore();
      test_reset_mid_conv();
      test_display_en();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
